dvs_event_fifo_fwft: RTL and testbench
======================================

// Module: dvs_event_fifo_fwft
// PURPOSE
//  Parametrised first-word-fall-through (FWFT) event FIFO between the DVS event capture front end and the RAVENS-side consumer.
//  - Replaces the fixed-depth queue.
//  - All DEPTH entries are usable: pointers carry an extra wrap bit.
//  - Ready/valid handshakes on both sides.
//  - Provides occupancy count, an almost-full flag, a saturating drop counter for events lost on overflow, and a high-water mark.
// PARAMETERS
//  WIDTH         16   event word width in bits (>=1)
//  DEPTH         16   entries; power of two, >=2
//  AFULL_THRESH  12   almost_full asserts when level >= AFULL_THRESH (1..DEPTH)
//  DROP_W        16   drop counter width; counter saturates
// PORTS
//  clk          in   1                    clock, rising edge
//  rst_n        in   1                    reset, asynchronous, active-low
//  flush        in   1                    synchronous empty; discards all stored events
//  clr_stats    in   1                    synchronous clear of drop_cnt and high_water
//  in_valid     in   1                    producer has event on in_data
//  in_ready     out  1                    FIFO can accept (= !full)
//  in_data      in   WIDTH                event word
//  out_valid    out  1                    out_data holds oldest event (= !empty)
//  out_ready    in   1                    consumer takes out_data this cycle
//  out_data     out  WIDTH                oldest stored event; X/don't-care when !out_valid
//  level        out  $clog2(DEPTH)+1      current occupancy, 0..DEPTH
//  almost_full  out  1                    level >= AFULL_THRESH
//  overflow     out  1                    1-cycle pulse: event dropped this cycle
//  drop_cnt     out  DROP_W               saturating count of dropped events
//  high_water   out  $clog2(DEPTH)+1      max level seen since reset/clr_stats
// BEHAVIOUR
//  Reset (rst_n low, async):
//  - Pointers, level, drop_cnt, high_water = 0; overflow = 0.
//  - Hence in_ready = 1, out_valid = 0, almost_full = 0.
//  - Storage array is not reset.
//  Handshakes:
//  - push = in_valid & in_ready.
//  - pop = out_valid & out_ready.
//  - in_ready depends only on registered state; no comb path from out_ready.
//  Storage and latency:
//  - out_data = mem[rd_ptr] read combinationally (FWFT).
//  - Word pushed in cycle N is visible, with out_valid = 1, in cycle N+1 when the FIFO was empty.
//  Pointers:
//  - rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits.
//  - empty = (wr_ptr == rd_ptr).
//  - full = (MSBs differ, lower bits equal).
//  - Wrap is natural binary rollover.
//  - level = wr_ptr - rd_ptr, registered-state derived.
//  Simultaneous push and pop:
//  - Both take effect; level unchanged.
//  - When empty, pop cannot occur (out_valid = 0); push proceeds.
//  - When full, push cannot occur (in_ready = 0); pop proceeds.
//  Overflow:
//  - in_valid & full is a drop, not a stall: event discarded, overflow = 1 next cycle.
//  - drop_cnt += 1, holding at 2^DROP_W-1.
//  - The DVS source cannot be back-pressured, so producers must treat in_ready as advisory.
//  high_water:
//  - Updated each cycle to max(high_water, next level).
//  flush:
//  - Next cycle rd_ptr = wr_ptr = 0 and level = 0.
//  - Push/pop in the flush cycle are ignored and not counted as drops.
//  clr_stats:
//  - Next cycle drop_cnt = 0 and high_water = next level.
//  - A drop in the same cycle yields drop_cnt = 1.
//  Priority: rst_n > flush > normal operation; clr_stats is independent of flush.
//  Reset mid-operation:
//  - All state returns to the reset values above immediately.
//  - Stored events are lost.
// TESTING
//  T1 reset:
//  - Assert rst_n low mid-burst -> in_ready = 1, out_valid = 0, level = 0, drop_cnt = 0 asynchronously.
//  T2 FWFT latency:
//  - Push 0x00A5 into empty FIFO at cycle N -> out_valid = 1 and out_data = 0x00A5 at N+1.
//  - level = 1; pop at N+1 -> empty at N+2.
//  T3 full depth:
//  - Push 16 distinct words, out_ready = 0 -> level = 16, in_ready = 0.
//  - almost_full = 1 from the 12th push onward.
//  - Drain returns all 16 words in order.
//  T4 overflow:
//  - With FIFO full, hold in_valid for 3 cycles -> overflow pulses 3 times, drop_cnt = 3, contents unchanged.
//  - With DROP_W = 2 and 5 drops -> drop_cnt = 3.
//  T5 simultaneous:
//  - At level 8 push+pop every cycle for 40 cycles (wraps pointers twice) -> level stays 8, data order preserved.
//  - high_water = 8.
//  T6 flush/clr_stats:
//  - level = 10, assert flush with in_valid = 1 -> next cycle level = 0, no drop counted, high_water = 10.
//  - Then clr_stats -> high_water = 0, drop_cnt = 0.

Source files
------------

// File: rtl/dvs_event_fifo_fwft.sv
// rtl/dvs_event_fifo_fwft.sv - first-word-fall-through DVS event FIFO with drop/high-water stats
module dvs_event_fifo_fwft #(
   parameter int WIDTH        = 16,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12,
   parameter int DROP_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       clr_stats,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       almost_full,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_cnt,
   output logic [$clog2(DEPTH):0]     high_water
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    level_nxt;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign in_ready    = ~full;
   assign out_valid   = ~empty;
   assign out_data    = mem[rd_ptr[AW-1:0]];
   assign level       = wr_ptr - rd_ptr;
   assign almost_full = (level >= PW'(AFULL_THRESH));

   // A flush cycle swallows any handshake and is never counted as a drop.
   assign push = in_valid & ~full & ~flush;
   assign pop  = out_ready & ~empty & ~flush;
   assign drop = in_valid & full & ~flush;

   always_comb begin
      level_nxt = level + PW'(push) - PW'(pop);
      if (flush) begin
         level_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_cnt   <= '0;
         high_water <= '0;
      end else begin
         overflow <= drop;
         if (clr_stats) begin
            drop_cnt   <= drop ? DROP_W'(1) : '0;
            high_water <= level_nxt;
         end else begin
            if (drop && (drop_cnt != DROP_MAX)) begin
               drop_cnt <= drop_cnt + DROP_W'(1);
            end
            if (level_nxt > high_water) begin
               high_water <= level_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_dvs_event_fifo_fwft.sv
// tb/tb_dvs_event_fifo_fwft.sv - directed self-checking bench for dvs_event_fifo_fwft
module tb_dvs_event_fifo_fwft;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0, clr_stats = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, out_valid, almost_full, overflow;
   logic [15:0] out_data, drop_cnt;
   logic [4:0]  level, high_water;

   logic        flush2 = 1'b0, clr2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
   logic [7:0]  in_data2 = '0;
   logic        in_ready2, out_valid2, almost_full2, overflow2;
   logic [7:0]  out_data2;
   logic [1:0]  drop_cnt2, level2, high_water2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dvs_event_fifo_fwft #(.WIDTH(16), .DEPTH(16), .AFULL_THRESH(12), .DROP_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .almost_full(almost_full), .overflow(overflow),
      .drop_cnt(drop_cnt), .high_water(high_water)
   );

   dvs_event_fifo_fwft #(.WIDTH(8), .DEPTH(2), .AFULL_THRESH(2), .DROP_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush2), .clr_stats(clr2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .level(level2), .almost_full(almost_full2), .overflow(overflow2),
      .drop_cnt(drop_cnt2), .high_water(high_water2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%0b exp=0", almost_full); end
      checks++; if (drop_cnt !== 16'd0 || high_water !== 5'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL reset_stats got=%0d/%0d/%0b exp=0/0/0", drop_cnt, high_water, overflow);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fwft();
      in_valid = 1'b1; in_data = 16'h00A5;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h00A5) begin
         errors++; $display("FAIL fwft_data got=%0b/%h exp=1/00a5", out_valid, out_data);
      end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL fwft_level got=%0d exp=1", level); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin
         errors++; $display("FAIL fwft_empty got=%0b/%0d exp=0/0", out_valid, level);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 16'h1000 + 16'(i);
         step();
         checks++; if (level !== 5'(i + 1)) begin errors++; $display("FAIL full_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
         checks++; if (almost_full !== (i + 1 >= 12)) begin
            errors++; $display("FAIL full_afull[%0d] got=%0b exp=%0b", i, almost_full, (i + 1 >= 12));
         end
      end
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
   endtask

   task automatic test_overflow();
      in_valid = 1'b1; in_data = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse[%0d] got=%0b exp=1", i, overflow); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
      checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", level); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (out_data !== 16'h1000 + 16'(i)) begin
            errors++; $display("FAIL drain[%0d] got=%h exp=%h", i, out_data, 16'h1000 + 16'(i));
         end
         step();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
      checks++; if (high_water !== 5'd16) begin errors++; $display("FAIL drain_hw got=%0d exp=16", high_water); end
   endtask

   task automatic test_drop_saturate();
      in_valid2 = 1'b1;
      in_data2 = 8'h11; step();
      in_data2 = 8'h22; step();
      in_data2 = 8'h33;
      for (int i = 0; i < 3; i++) step();
      checks++; if (drop_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_three got=%0d exp=3", drop_cnt2); end
      for (int i = 0; i < 2; i++) step();
      in_valid2 = 1'b0;
      checks++; if (drop_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_five got=%0d exp=3", drop_cnt2); end
      checks++; if (level2 !== 2'd2 || out_data2 !== 8'h11) begin
         errors++; $display("FAIL sat_contents got=%0d/%h exp=2/11", level2, out_data2);
      end
   endtask

   task automatic test_back_to_back();
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      checks++; if (high_water !== 5'd0 || drop_cnt !== 16'd0) begin
         errors++; $display("FAIL b2b_clr got=%0d/%0d exp=0/0", high_water, drop_cnt);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin in_data = 16'h2000 + 16'(i); step(); end
      out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         in_data = 16'h2008 + 16'(k);
         checks++; if (out_data !== 16'h2000 + 16'(k)) begin
            errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, out_data, 16'h2000 + 16'(k));
         end
         step();
         checks++; if (level !== 5'd8) begin errors++; $display("FAIL b2b_level[%0d] got=%0d exp=8", k, level); end
      end
      in_valid = 1'b0;
      for (int k = 40; k < 48; k++) begin
         checks++; if (out_data !== 16'h2000 + 16'(k)) begin
            errors++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", k, out_data, 16'h2000 + 16'(k));
         end
         step();
      end
      out_ready = 1'b0;
      checks++; if (high_water !== 5'd8 || level !== 5'd0) begin
         errors++; $display("FAIL b2b_hw got=%0d/%0d exp=8/0", high_water, level);
      end
   endtask

   task automatic test_flush_stats();
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin in_data = 16'h3000 + 16'(i); step(); end
      flush = 1'b1; step(); flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_level got=%0d/%0b exp=0/0", level, out_valid);
      end
      checks++; if (high_water !== 5'd10 || drop_cnt !== 16'd0) begin
         errors++; $display("FAIL flush_stats got=%0d/%0d exp=10/0", high_water, drop_cnt);
      end
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      checks++; if (high_water !== 5'd0 || drop_cnt !== 16'd0) begin
         errors++; $display("FAIL clr_stats got=%0d/%0d exp=0/0", high_water, drop_cnt);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin in_data = 16'h4000 + 16'(i); step(); end
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      checks++; if (drop_cnt !== 16'd1 || high_water !== 5'd16) begin
         errors++; $display("FAIL clr_with_drop got=%0d/%0d exp=1/16", drop_cnt, high_water);
      end
      flush = 1'b1; step(); flush = 1'b0;
      checks++; if (drop_cnt !== 16'd1 || overflow !== 1'b0 || level !== 5'd0) begin
         errors++; $display("FAIL flush_full got=%0d/%0b/%0d exp=1/0/0", drop_cnt, overflow, level);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin in_data = 16'h5000 + 16'(i); step(); end
      rst_n = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_hs got=%0b/%0b exp=1/0", in_ready, out_valid);
      end
      checks++; if (level !== 5'd0 || drop_cnt !== 16'd0 || high_water !== 5'd0) begin
         errors++; $display("FAIL midrst_state got=%0d/%0d/%0d exp=0/0/0", level, drop_cnt, high_water);
      end
      checks++; if (level2 !== 2'd0 || drop_cnt2 !== 2'd0) begin
         errors++; $display("FAIL midrst_dut2 got=%0d/%0d exp=0/0", level2, drop_cnt2);
      end
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_fwft();
      test_full();
      test_overflow();
      test_drop_saturate();
      test_back_to_back();
      test_flush_stats();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
